// File: rtl/mem8x8_pkg.sv
// Shared sizing defaults and FSM state encoding for the 8x8 RAM access controller.
package mem8x8_pkg;

    // Default RAM geometry
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    // Default number of cycles ram_sel is held high per access (legal 1..15)
    localparam int DEF_STROBE_CYCLES = 1;

    // FSM state encoding, kept as plain constants for compatibility with older tools
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

endpackage

// File: rtl/mem8x8_ctrl.sv
// Access controller for the 8x8 tri-state-output RAM.
// Turns valid/ready read/write requests into a setup / strobe / release sequence
// on the RAM's level-sensitive pins, returns read data on a valid/ready response
// channel, and can sweep every address writing zero (clear-all).
// The ram_addr/ram_op/ram_inp registers double as the latched request, so they
// stay stable from setup through release and hold their value while idle.
module mem8x8_ctrl
    import mem8x8_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_sel,
    output logic              ram_op,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_inp,
    input  logic [DATA_W-1:0] ram_outp
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    // Strobe counter counts down to zero, so it is loaded with one less than the width
    localparam logic [3:0]        STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    logic [2:0]        state_reg;
    logic [3:0]        strobe_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              clr_mode_reg;

    // Sequencer: FSM, strobe/clear counters and every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            strobe_cnt_reg <= '0;
            clr_cnt_reg    <= '0;
            clr_mode_reg   <= 1'b0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            clr_busy       <= 1'b0;
            clr_done       <= 1'b0;
            ram_sel        <= 1'b0;
            ram_op         <= 1'b0;
            ram_addr       <= '0;
            ram_inp        <= '0;
        end else begin
            // clr_done is a single-cycle pulse
            clr_done <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (clr_start) begin
                        // Clear wins over a simultaneous request; the request stays pending
                        clr_mode_reg <= 1'b1;
                        clr_cnt_reg  <= '0;
                        clr_busy     <= 1'b1;
                        ram_addr     <= '0;
                        ram_op       <= 1'b1;
                        ram_inp      <= '0;
                        req_ready    <= 1'b0;
                        state_reg    <= ST_SETUP;
                    end else if (req_valid && req_ready) begin
                        clr_mode_reg <= 1'b0;
                        ram_addr     <= req_addr;
                        ram_op       <= req_write;
                        ram_inp      <= req_wdata;
                        req_ready    <= 1'b0;
                        state_reg    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // Address/op/data have been stable for a full cycle; now select
                    ram_sel        <= 1'b1;
                    strobe_cnt_reg <= STROBE_LOAD;
                    state_reg      <= ST_STROBE;
                end

                ST_STROBE: begin
                    if (strobe_cnt_reg == 4'd0) begin
                        ram_sel   <= 1'b0;
                        state_reg <= ST_RELEASE;
                        // Read data is only driven while selected, so sample on the last strobe cycle
                        if (!ram_op) begin
                            rsp_data <= ram_outp;
                        end
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg - 4'd1;
                    end
                end

                ST_RELEASE: begin
                    if (clr_mode_reg) begin
                        if (clr_cnt_reg != LAST_ADDR) begin
                            clr_cnt_reg <= clr_cnt_reg + 1'b1;
                            ram_addr    <= clr_cnt_reg + 1'b1;
                            state_reg   <= ST_SETUP;
                        end else begin
                            clr_mode_reg <= 1'b0;
                            clr_busy     <= 1'b0;
                            clr_done     <= 1'b1;
                            req_ready    <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end
                    end else if (ram_op) begin
                        req_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Hold the response until the consumer takes it; no new requests meanwhile
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    ram_sel   <= 1'b0;
                    req_ready <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem8x8_ctrl.md
Name: mem8x8_ctrl

Overview:
- Synchronous access controller sitting directly upstream of the 8x8 tri-state-output RAM.
- Accepts read/write requests over a valid/ready handshake and generates the RAM's level-sensitive sel/op/addr/inp sequence: setup, strobe, release.
- Captures read data from the RAM output bus and returns it on a valid/ready response channel.
- Also provides a clear-all sequence that writes zero to every address.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W = 8.
- STROBE_CYCLES, 1, number of cycles ram_sel is held high per access; legal range 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DATA_W  captured read data.
- clr_start  in  1  single-cycle pulse that starts a clear-all.
- clr_busy  out  1  clear-all in progress.
- clr_done  out  1  one-cycle pulse when clear-all completes.
- ram_sel  out  1  RAM select (active high).
- ram_op  out  1  RAM operation: 1 = write, 0 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_inp  out  DATA_W  RAM write data.
- ram_outp  in  DATA_W  RAM output bus; high-Z when RAM is not selected for a read.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (applied asynchronously, including mid-access):
  - all outputs 0: req_ready, rsp_valid, rsp_data, clr_busy, clr_done, ram_sel, ram_op, ram_addr, ram_inp.
  - state IDLE; clear counter 0.
  - req_ready rises the first cycle after rst_n deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, RELEASE, RESP.
- IDLE:
  - req_ready = 1; ram_sel = 0; ram_addr, ram_op and ram_inp hold their last values.
  - clr_start = 1 has priority over req_valid in the same cycle: latch clear mode, counter = 0, go to SETUP; the request is not accepted (req_ready drops next cycle).
  - Otherwise req_valid && req_ready latches write/addr/wdata and goes to SETUP.
- SETUP (1 cycle):
  - ram_addr, ram_op and ram_inp are driven with the new values; ram_sel = 0.
  - In clear mode: ram_op = 1, ram_inp = 0, ram_addr = counter.
- STROBE (STROBE_CYCLES cycles, tracked by a down-counter):
  - ram_sel = 1; addr, op and inp are held stable.
  - For a read, ram_outp is sampled into rsp_data on the last STROBE cycle.
- RELEASE (1 cycle):
  - ram_sel = 0; addr, op and inp still held, so there is no glitch on deselect.
  - Clear mode with counter < DEPTH-1: increment counter and go to SETUP.
  - Clear mode with counter == DEPTH-1: clr_done = 1 next cycle, then IDLE.
  - Read: go to RESP. Write: go to IDLE.
- RESP:
  - rsp_valid = 1 and rsp_data held until rsp_ready = 1; then rsp_valid drops and the FSM returns to IDLE.
  - req_ready stays 0 throughout (back-pressure).
- Latency, with S = STROBE_CYCLES and the accept edge at cycle T:
  - Write: SETUP at T+1, STROBE T+2..T+1+S, RELEASE T+2+S, req_ready = 1 at T+3+S.
  - Read: rsp_valid first high at T+3+S; earliest next accept at T+4+S.
- Clear-all:
  - clr_busy = 1 from the cycle after clr_start until the cycle clr_done pulses; clr_busy = 0 in that clr_done cycle.
  - Total duration is DEPTH*(S+2) cycles.
  - req_ready = 0 throughout.
- Boundary conditions:
  - clr_start outside IDLE is ignored, with no queuing.
  - req_valid dropping while req_ready = 0 has no effect.
  - rsp_ready asserted while rsp_valid = 0 is ignored.
  - ram_addr wraps only in clear mode; the counter stops at DEPTH-1.
  - Z/X on ram_outp is captured as-is, and only during STROBE of a read.

Decomposition:
- Package mem8x8_pkg holds:
  - DATA_W and ADDR_W defaults;
  - DEPTH;
  - the FSM state encoding (IDLE, SETUP, STROBE, RELEASE, RESP) as localparams;
  - the default STROBE_CYCLES.
- No sub-module is needed. The strobe down-counter, clear counter and FSM live in mem8x8_ctrl; the existing ram module is instantiated only in the bench.

Test Plan:
1. Reset then write AA to addr 1, then read addr 1 (S=1) -> ram_sel high exactly 1 cycle per access; rsp_valid at T+4; rsp_data = 8'hAA.
2. Write CC to 2 and F0 to 3, then read 3 and read 2 with rsp_ready held low 5 cycles -> rsp_valid and rsp_data = 8'hF0 stable 5 cycles, req_ready = 0 meanwhile; then 8'hCC.
3. STROBE_CYCLES=3: write 55 to 6, read 6 -> ram_sel high 3 consecutive cycles; addr/op stable from SETUP through RELEASE; rsp_data = 8'h55.
4. Fill all 8 addresses (01..80), pulse clr_start -> clr_busy high 24 cycles (S=1); clr_done single pulse; reads of addr 0..7 all return 8'h00.
5. clr_start and req_valid (write 99 to 7) asserted in the same IDLE cycle -> clear runs and the write is not accepted; after clr_done, the held request is accepted and a read of addr 7 returns 8'h99.
6. Assert rst_n low during STROBE of a write of 33 to 5 -> ram_sel = 0 immediately (asynchronously); all outputs at reset values; req_ready = 1 one cycle after release.
